multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core. Sequences fetch, decode/immediate-latch,
//  execute, memory and writeback over a shared memory port and a single ALU. Drives the datapath
//  muxes and write enables from IR opcode, traps on illegal opcodes or a memory timeout, and counts
//  retired instructions.
// PARAMETERS
//  TIMEOUT  16  max cycles waiting on mem_ready in FETCH/MEM before bus trap; 0 = never time out
//  CNT_W    32  width of instret counter
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  opcode        in   7      IR[6:0] (valid from DECODE onward)
//  branch_taken  in   1      branch comparator result, sampled in EXEC
//  mem_ready     in   1      memory handshake: request completes this cycle
//  mem_req       out  1      memory request (held until mem_ready)
//  mem_we        out  1      store strobe (only with mem_req in MEM)
//  mem_addr_sel  out  1      0=PC, 1=ALU result
//  ir_we         out  1      latch instruction register
//  imm_we        out  1      latch immediate-generator output
//  alu_a_sel     out  1      0=rs1, 1=PC
//  alu_b_sel     out  1      0=rs2, 1=imm
//  reg_we        out  1      register-file write enable
//  wb_sel        out  2      0=ALU, 1=mem data, 2=PC+4, 3=imm
//  pc_we         out  1      PC update
//  pc_sel        out  2      0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
//  trap          out  1      sticky trap flag
//  trap_cause    out  1      0=illegal opcode, 1=memory timeout
//  state         out  3      current state (debug)
//  instret       out  CNT_W  retired-instruction count, wraps
// BEHAVIOUR
//  States: RST=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6. Outputs are Moore decode of state/opcode,
//   except ir_we = FETCH&mem_ready and MEM/branch pc_we as noted. Unlisted outputs are 0.
//  Reset: state=RST; all outputs 0, instret=0, wait_cnt=0, trap=0. RST->FETCH on first clock.
//   Reset mid-transaction abandons it immediately (mem_req drops asynchronously).
//  FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir_we=1 -> DECODE.
//  DECODE: imm_we=1. Opcode routing:
//   0110011 OP, 0010011 OP-IMM, 0010111 AUIPC, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH,
//   1101111 JAL, 1100111 JALR -> EXEC; 0110111 LUI -> WB; any other -> TRAP (cause 0).
//  EXEC: alu_b_sel=1 for OP-IMM/LOAD/STORE/AUIPC/JALR; alu_a_sel=1 for AUIPC.
//   LOAD/STORE -> MEM. BRANCH: pc_we=1, pc_sel=branch_taken?1:0, retire -> FETCH. Others -> WB.
//  MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). On mem_ready: LOAD -> WB;
//   STORE: pc_we=1, pc_sel=0, retire -> FETCH.
//  WB: pc_we=1, reg_we=1, retire -> FETCH. wb_sel: OP/OP-IMM/AUIPC=0, LOAD=1, JAL/JALR=2, LUI=3.
//   pc_sel: JAL=1, JALR=2, else 0.
//  TRAP: absorbing until reset; all strobes 0, trap=1, trap_cause held, instret frozen.
//  Timeout: wait_cnt clears on entering FETCH or MEM; increments on each cycle there with
//   mem_ready=0. If mem_ready=0 and wait_cnt==TIMEOUT-1 -> TRAP (cause 1) on that edge.
//   mem_ready on the limit cycle wins (no trap). TIMEOUT=0: counter inactive.
//  Retire: instret += 1 on the edge leaving the retiring state; wraps 2^CNT_W-1 -> 0.
//  mem_ready outside FETCH/MEM is ignored. Cycles/instr with zero-wait memory:
//   ALU/AUIPC/JAL/JALR 4, LUI 3, BRANCH 3, STORE 4, LOAD 5.
// TESTING
//  Reset release, mem_ready=1 always, ADDI 0x00500093 -> states 0,1,2,3,5,1; reg_we/pc_we in WB
//   only; wb_sel=0; instret=1.
//  LW 0x0000A103, mem_ready delayed 3 cycles in MEM -> mem_req held, mem_addr_sel=1, mem_we=0;
//   WB wb_sel=1; 8 cycles total.
//  BEQ with branch_taken=1 then 0 -> EXEC pc_we=1, pc_sel=1 then 0; no reg_we; instret +1 each.
//  Opcode 7'b1111111 -> TRAP after DECODE, trap=1, trap_cause=0; further mem_ready has no effect.
//  TIMEOUT=4, mem_ready=0 in FETCH -> TRAP cause 1 after exactly 4 FETCH cycles;
//   ready on 4th cycle -> no trap.
//  CNT_W=4, 16 LUIs -> instret wraps to 0; rst_n low mid-MEM -> mem_req=0 immediately, state=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/exec/mem/wb sequencing over one memory port,
// with datapath select decode, illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             imm_we,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             trap,
    output logic             trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int              WW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0]   WAIT_LIM = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             r_state;
    logic [WW-1:0]      r_wait_cnt;
    logic [CNT_W-1:0]   r_instret;
    logic               r_trap_cause;

    logic w_is_op, w_is_opimm, w_is_auipc, w_is_lui, w_is_load, w_is_store;
    logic w_is_branch, w_is_jal, w_is_jalr, w_to_exec;
    logic w_mem_phase, w_timeout, w_retire;

    assign w_is_op     = (opcode == OP_OP);
    assign w_is_opimm  = (opcode == OP_OPIMM);
    assign w_is_auipc  = (opcode == OP_AUIPC);
    assign w_is_lui    = (opcode == OP_LUI);
    assign w_is_load   = (opcode == OP_LOAD);
    assign w_is_store  = (opcode == OP_STORE);
    assign w_is_branch = (opcode == OP_BRANCH);
    assign w_is_jal    = (opcode == OP_JAL);
    assign w_is_jalr   = (opcode == OP_JALR);
    assign w_to_exec   = w_is_op | w_is_opimm | w_is_auipc | w_is_load | w_is_store
                       | w_is_branch | w_is_jal | w_is_jalr;

    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = (TIMEOUT != 0) && w_mem_phase && !mem_ready && (r_wait_cnt == WAIT_LIM);
    assign w_retire    = ((r_state == S_EXEC) && w_is_branch)
                       || ((r_state == S_MEM) && mem_ready && !w_is_load)
                       || (r_state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RST;
            r_wait_cnt   <= '0;
            r_instret    <= '0;
            r_trap_cause <= 1'b0;
        end else begin
            // Counter only runs while stalled on memory; any other cycle rearms it.
            if (w_mem_phase && !mem_ready && TIMEOUT != 0)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            if (w_retire)
                r_instret <= r_instret + 1'b1;

            case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap_cause <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_is_lui) begin
                        r_state <= S_WB;
                    end else if (w_to_exec) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state      <= S_TRAP;
                        r_trap_cause <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (w_is_load || w_is_store)
                        r_state <= S_MEM;
                    else if (w_is_branch)
                        r_state <= S_FETCH;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= w_is_load ? S_WB : S_FETCH;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap_cause <= 1'b1;
                    end
                end
                S_WB:     r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_RST;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        imm_we       = 1'b0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_DECODE: imm_we = 1'b1;
            S_EXEC: begin
                alu_b_sel = w_is_opimm | w_is_load | w_is_store | w_is_auipc | w_is_jalr;
                alu_a_sel = w_is_auipc;
                if (w_is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = {1'b0, branch_taken};
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                pc_we        = mem_ready && !w_is_load;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                if (w_is_load)                  wb_sel = 2'd1;
                else if (w_is_jal || w_is_jalr) wb_sel = 2'd2;
                else if (w_is_lui)              wb_sel = 2'd3;
                else                            wb_sel = 2'd0;
                if (w_is_jal)       pc_sel = 2'd1;
                else if (w_is_jalr) pc_sel = 2'd2;
                else                pc_sel = 2'd0;
            end
            default: ;
        endcase
    end

    assign state      = r_state;
    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expands each instruction into its expected per-cycle behaviour and compares every cycle.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, imm_we, alu_a_sel, alu_b_sel, reg_we;
    logic [1:0] wb_sel, pc_sel;
    logic       pc_we, trap, trap_cause;
    logic [2:0] state;
    logic [3:0] instret;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .imm_we(imm_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap),
        .trap_cause(trap_cause), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_OP = 7'b0110011, OP_OPIMM = 7'b0010011, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    typedef struct packed {
        logic       mem_req, mem_we, mem_addr_sel, ir_we, imm_we, alu_a_sel, alu_b_sel, reg_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       rdy, bt;
        logic [2:0] st;
        outs_t      o;
        logic       trp, cause, ret;
    } cyc_t;

    cyc_t plan[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_instret = 0;
    logic force_rdy = 1'b0;

    logic [21:0] obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, imm_we, alu_a_sel, alu_b_sel,
                  reg_we, wb_sel, pc_we, pc_sel, trap, trap_cause, instret};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [6:0] op, input logic [2:0] st);
        cyc_t c;
        c.op    = op;
        c.rdy   = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
        c.bt    = 1'($urandom_range(0, 1));
        c.st    = st;
        c.o     = '0;
        c.trp   = 1'b0;
        c.cause = 1'b0;
        c.ret   = 1'b0;
        return c;
    endfunction

    task automatic push_trap(input logic [6:0] op, input logic cause, input int n);
        cyc_t c;
        for (int k = 0; k < n; k++) begin
            c = blank(op, 3'd6);
            c.rdy   = 1'($urandom_range(0, 1));
            c.trp   = 1'b1;
            c.cause = cause;
            plan.push_back(c);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one instruction; waits >= TO end in a bus trap.
    task automatic plan_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
        cyc_t c;
        logic lui, ld, st, br, legal;
        lui = (op == OP_LUI); ld = (op == OP_LOAD); st = (op == OP_STORE); br = (op == OP_BR);
        legal = op inside {OP_OP, OP_OPIMM, OP_AUIPC, OP_LUI, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};
        for (int k = 0; k < fw && k < TO; k++) begin
            c = blank(op, 3'd1); c.rdy = 1'b0; c.o.mem_req = 1'b1; plan.push_back(c);
        end
        if (fw >= TO) begin push_trap(op, 1'b1, 3); return; end
        c = blank(op, 3'd1); c.rdy = 1'b1; c.o.mem_req = 1'b1; c.o.ir_we = 1'b1; plan.push_back(c);
        c = blank(op, 3'd2); c.o.imm_we = 1'b1; plan.push_back(c);
        if (!legal) begin push_trap(op, 1'b0, 4); return; end
        if (!lui) begin
            c = blank(op, 3'd3);
            c.bt = bt;
            c.o.alu_b_sel = op inside {OP_OPIMM, OP_LOAD, OP_STORE, OP_AUIPC, OP_JALR};
            c.o.alu_a_sel = (op == OP_AUIPC);
            if (br) begin c.o.pc_we = 1'b1; c.o.pc_sel = {1'b0, bt}; c.ret = 1'b1; end
            plan.push_back(c);
        end
        if (ld || st) begin
            for (int k = 0; k < mw && k < TO; k++) begin
                c = blank(op, 3'd4); c.rdy = 1'b0;
                c.o.mem_req = 1'b1; c.o.mem_addr_sel = 1'b1; c.o.mem_we = st;
                plan.push_back(c);
            end
            if (mw >= TO) begin push_trap(op, 1'b1, 3); return; end
            c = blank(op, 3'd4); c.rdy = 1'b1;
            c.o.mem_req = 1'b1; c.o.mem_addr_sel = 1'b1; c.o.mem_we = st;
            if (st) begin c.o.pc_we = 1'b1; c.ret = 1'b1; end
            plan.push_back(c);
        end
        if (!br && !st) begin
            c = blank(op, 3'd5);
            c.o.reg_we = 1'b1; c.o.pc_we = 1'b1; c.ret = 1'b1;
            c.o.wb_sel = ld ? 2'd1 : lui ? 2'd3 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
            c.o.pc_sel = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
            plan.push_back(c);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_n(input int n, input string tag);
        cyc_t c;
        for (int k = 0; k < n && plan.size() > 0; k++) begin
            c = plan.pop_front();
            opcode = c.op; mem_ready = c.rdy; branch_taken = c.bt;
            @(negedge clk);
            check(tag, 32'(obs), 32'({c.st, c.o, c.trp, c.cause, 4'(m_instret)}));
            if (c.ret) m_instret++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        check({tag, "_async"}, 32'(obs), 32'd0);
        m_instret = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_rst_state"}, 32'(obs), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal_ops [9];
        legal_ops = '{OP_OP, OP_OPIMM, OP_AUIPC, OP_LUI, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 32'(obs), 32'd0);
        do_reset("reset");

        force_rdy = 1'b1;
        plan_instr(7'(32'h00500093), 0, 0, 1'b0);
        run_n(100, "addi");
        force_rdy = 1'b0;

        plan_instr(7'(32'h0000A103), 0, 3, 1'b0);
        run_n(100, "lw_wait3");

        plan_instr(OP_BR, 0, 0, 1'b1);
        plan_instr(OP_BR, 0, 0, 1'b0);
        run_n(100, "beq");

        plan_instr(OP_STORE, TO - 1, TO - 1, 1'b0);
        run_n(100, "ready_on_limit");

        for (int i = 0; i < 150; i++) begin
            plan_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            run_n(100, "random");
        end

        plan_instr(7'b1111111, 0, 0, 1'b0);
        run_n(100, "illegal_trap");
        do_reset("after_illegal");

        plan_instr(OP_OP, TO, 0, 1'b0);
        run_n(100, "fetch_timeout");
        do_reset("after_fetch_to");

        plan_instr(OP_LOAD, 1, TO, 1'b0);
        run_n(100, "mem_timeout");
        do_reset("after_mem_to");

        for (int i = 0; i < 16; i++) begin
            plan_instr(OP_LUI, 0, 0, 1'b0);
            run_n(100, "lui_wrap");
        end
        check("instret_wrap", 32'(instret), 32'd0);

        plan_instr(OP_LOAD, 0, 3, 1'b0);
        run_n(4, "mid_mem");
        mem_ready = 1'b0;
        #1;
        check("mid_mem_req", 32'({state, mem_req}), 32'({3'd4, 1'b1}));
        plan.delete();
        do_reset("mid_mem_reset");

        plan_instr(OP_JAL, 0, 0, 1'b0);
        run_n(100, "post_reset_jal");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
